// File: rtl/hdmi_pixel_packer.sv
// rtl/hdmi_pixel_packer.sv - packs 24-bit HDMI pixels into 32-bit LE words behind a FWFT FIFO
module hdmi_pixel_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int WCNT_W     = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [23:0]                   pix_data,
    input  logic                          pix_de,
    input  logic                          pix_vs,
    output logic [31:0]                   word_data,
    output logic                          word_sof,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clear,
    output logic                          frame_done,
    output logic [WCNT_W-1:0]             frame_words
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    phase_t              phase, phase_nxt;
    logic                vs_d;
    logic                armed;
    logic                sof_pend;
    logic [23:0]         hold;
    logic [WCNT_W-1:0]   wcnt, wcnt_inc;
    logic                rise, fall, pix_take;
    logic                push;
    logic [31:0]         push_data;

    logic [32:0]         mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic [32:0]         head;
    logic                full, pop, wr_en, drop;

    // Falls only matter once armed, so a reset mid-frame cannot flush or report a partial frame.
    assign rise     = pix_vs & ~vs_d;
    assign fall     = ~pix_vs & vs_d & armed;
    assign pix_take = armed & pix_vs & pix_de & ~rise;

    always_comb begin
        phase_nxt = phase;
        push      = 1'b0;
        push_data = '0;
        if (rise) begin
            phase_nxt = PH0;
        end else if (fall) begin
            phase_nxt = PH0;
            case (phase)
                PH1: begin push = 1'b1; push_data = {8'h00, hold};        end
                PH2: begin push = 1'b1; push_data = {16'h0, hold[23:8]};  end
                PH3: begin push = 1'b1; push_data = {24'h0, hold[23:16]}; end
                default: ;
            endcase
        end else if (pix_take) begin
            case (phase)
                PH0: phase_nxt = PH1;
                PH1: begin
                    phase_nxt = PH2;
                    push      = 1'b1;
                    push_data = {pix_data[7:0], hold};
                end
                PH2: begin
                    phase_nxt = PH3;
                    push      = 1'b1;
                    push_data = {pix_data[15:0], hold[23:8]};
                end
                default: begin
                    phase_nxt = PH0;
                    push      = 1'b1;
                    push_data = {pix_data, hold[23:16]};
                end
            endcase
        end
    end

    assign wcnt_inc = (push && (wcnt != '1)) ? wcnt + 1'b1 : wcnt;

    // vs_d resets high so a frame already active when reset lifts is not seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= PH0;
            vs_d        <= 1'b1;
            armed       <= 1'b0;
            sof_pend    <= 1'b0;
            hold        <= '0;
            wcnt        <= '0;
            frame_done  <= 1'b0;
            frame_words <= '0;
        end else begin
            phase      <= phase_nxt;
            vs_d       <= pix_vs;
            frame_done <= fall;
            wcnt       <= rise ? '0 : wcnt_inc;
            if (rise) armed <= 1'b1;
            if (pix_take) hold <= pix_data;
            if (rise) sof_pend <= 1'b1;
            else if (push) sof_pend <= 1'b0;
            if (fall) frame_words <= wcnt_inc;
        end
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign word_valid = (wr_ptr != rd_ptr);
    assign pop        = word_valid & word_ready;
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign word_data  = word_valid ? head[31:0] : 32'h0;
    assign word_sof   = word_valid & head[32];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {sof_pend, push_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (ovf_clear) overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
        end
    end

endmodule
